// File: rtl/optimsoc_config_streamer_if.sv
// rtl/optimsoc_config_streamer_if.sv - request/response bundle of the config streamer
interface optimsoc_config_streamer_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic [7:0]  req_len;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_err;

    // requester / consumer side
    modport master (
        output req_valid, req_addr, req_len, out_ready,
        input  req_ready, out_data, out_valid, out_last, out_err
    );

    // streamer side
    modport slave (
        input  req_valid, req_addr, req_len, out_ready,
        output req_ready, out_data, out_valid, out_last, out_err
    );
endinterface

// File: rtl/optimsoc_config_streamer.sv
// rtl/optimsoc_config_streamer.sv - read-only system information word server
package optimsoc_config;
    typedef enum logic [0:0] {PLAIN = 1'b0, EXTERNAL = 1'b1} lmem_style_t;

    typedef struct packed {
        logic [31:0]       NUMTILES;
        logic [31:0]       NUMCTS;
        logic [63:0][15:0] CTLIST;
        logic [31:0]       CORES_PER_TILE;
        logic [31:0]       GMEM_SIZE;
        logic [31:0]       GMEM_TILE;
        lmem_style_t       LMEM_STYLE;
        logic [31:0]       LMEM_SIZE;
        logic              NOC_ENABLE_VCHANNELS;
        logic              ENABLE_BOOTROM;
        logic              ENABLE_DM;
        logic              ENABLE_PGAS;
        logic              CORE_ENABLE_FPU;
        logic              CORE_ENABLE_PERFCOUNTERS;
        logic              NA_ENABLE_MPSIMPLE;
        logic              NA_ENABLE_DMA;
        logic              NA_DMA_GENIRQ;
        logic              USE_DEBUG;
        logic              DEBUG_STM;
        logic              DEBUG_CTM;
        logic              DEBUG_DEM_UART;
        logic              DEBUG_SM;
        logic [31:0]       TOTAL_NUM_CORES;
        logic [31:0]       DEBUG_NUM_MODS;
        logic [31:0]       NOC_FLIT_WIDTH;
        logic [31:0]       NOC_CHANNELS;
        logic [31:0]       DEBUG_MODS_PER_TILE;
        logic [31:0]       NA_DMA_ENTRIES;
    } config_t;
endpackage

module optimsoc_config_streamer #(
    parameter optimsoc_config::config_t CONFIG = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    optimsoc_config_streamer_if.slave    bus
);
    localparam int NUM_WORDS = 80;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t      state_q, state_d;
    logic [8:0]  addr_q, addr_d;
    logic [8:0]  rem_q, rem_d;
    logic [15:0] data_q;
    logic        err_q;
    logic        last_q;

    logic [15:0] map_words [NUM_WORDS];
    logic [15:0] word_d;
    logic        err_d;

    // flatten the static configuration into the published word map
    always_comb begin
        map_words[8'h00] = CONFIG.NUMTILES[15:0];
        map_words[8'h01] = CONFIG.NUMCTS[15:0];
        map_words[8'h02] = CONFIG.CORES_PER_TILE[15:0];
        map_words[8'h03] = CONFIG.GMEM_SIZE[15:0];
        map_words[8'h04] = CONFIG.GMEM_SIZE[31:16];
        map_words[8'h05] = CONFIG.GMEM_TILE[15:0];
        map_words[8'h06] = CONFIG.LMEM_SIZE[15:0];
        map_words[8'h07] = CONFIG.LMEM_SIZE[31:16];
        map_words[8'h08] = {1'b0,
                            CONFIG.LMEM_STYLE == optimsoc_config::PLAIN,
                            CONFIG.DEBUG_SM,
                            CONFIG.DEBUG_DEM_UART,
                            CONFIG.DEBUG_CTM,
                            CONFIG.DEBUG_STM,
                            CONFIG.USE_DEBUG,
                            CONFIG.NA_DMA_GENIRQ,
                            CONFIG.NA_ENABLE_DMA,
                            CONFIG.NA_ENABLE_MPSIMPLE,
                            CONFIG.CORE_ENABLE_PERFCOUNTERS,
                            CONFIG.CORE_ENABLE_FPU,
                            CONFIG.ENABLE_PGAS,
                            CONFIG.ENABLE_DM,
                            CONFIG.ENABLE_BOOTROM,
                            CONFIG.NOC_ENABLE_VCHANNELS};
        map_words[8'h09] = CONFIG.TOTAL_NUM_CORES[15:0];
        map_words[8'h0A] = CONFIG.DEBUG_NUM_MODS[15:0];
        map_words[8'h0B] = CONFIG.NOC_FLIT_WIDTH[15:0];
        map_words[8'h0C] = CONFIG.NOC_CHANNELS[15:0];
        map_words[8'h0D] = CONFIG.DEBUG_MODS_PER_TILE[15:0];
        map_words[8'h0E] = CONFIG.NA_DMA_ENTRIES[15:0];
        map_words[8'h0F] = 16'h0000;
        for (int i = 0; i < 64; i++) begin
            map_words[16 + i] = CONFIG.CTLIST[i];
        end
    end

    // word lookup for the address that will be presented next cycle
    always_comb begin
        err_d  = (addr_d >= 9'(NUM_WORDS));
        word_d = err_d ? 16'h0000 : map_words[addr_d[6:0]];
    end

    // next state, address/remaining counters and request acceptance
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        bus.req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    addr_d  = {1'b0, bus.req_addr};
                    rem_d   = (bus.req_len == 8'd0) ? 9'd256 : {1'b0, bus.req_len};
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (rem_q > 9'd1) begin
                        addr_d = addr_q + 9'd1;
                        rem_d  = rem_q - 9'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // registered state and output word; outputs read zero outside a burst
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 9'd0;
            rem_q   <= 9'd0;
            data_q  <= 16'h0000;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            if (state_d == STREAM) begin
                data_q <= word_d;
                err_q  <= err_d;
                last_q <= (rem_d == 9'd1);
            end else begin
                data_q <= 16'h0000;
                err_q  <= 1'b0;
                last_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = (state_q == STREAM);
    assign bus.out_data  = data_q;
    assign bus.out_err   = err_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_optimsoc_config_streamer.sv
// tb/tb_optimsoc_config_streamer.sv - directed bench for the config streamer
module tb_optimsoc_config_streamer;
    function automatic optimsoc_config::config_t make_cfg();
        optimsoc_config::config_t c;
        c = '0;
        c.NUMTILES             = 32'd4;
        c.NUMCTS               = 32'd4;
        c.CORES_PER_TILE       = 32'd1;
        c.GMEM_SIZE            = 32'h1234_5678;
        c.GMEM_TILE            = 32'd3;
        c.LMEM_STYLE           = optimsoc_config::EXTERNAL;
        c.LMEM_SIZE            = 32'h00AB_CDEF;
        c.NOC_ENABLE_VCHANNELS = 1'b1;
        c.ENABLE_BOOTROM       = 1'b1;
        c.USE_DEBUG            = 1'b1;
        c.TOTAL_NUM_CORES      = 32'd4;
        c.DEBUG_NUM_MODS       = 32'd9;
        c.NOC_FLIT_WIDTH       = 32'd32;
        c.NOC_CHANNELS         = 32'd2;
        c.DEBUG_MODS_PER_TILE  = 32'd2;
        c.NA_DMA_ENTRIES       = 32'd4;
        for (int i = 0; i < 64; i++) c.CTLIST[i] = 16'(i);
        return c;
    endfunction

    localparam optimsoc_config::config_t CFG = make_cfg();

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    optimsoc_config_streamer_if bus ();

    optimsoc_config_streamer #(.CONFIG(CFG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [22];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // independent expectation for the bench's configuration
    function automatic logic [16:0] model(int addr);
        case (addr)
            0:  return {1'b0, 16'h0004};
            1:  return {1'b0, 16'h0004};
            2:  return {1'b0, 16'h0001};
            3:  return {1'b0, 16'h5678};
            4:  return {1'b0, 16'h1234};
            5:  return {1'b0, 16'h0003};
            6:  return {1'b0, 16'hCDEF};
            7:  return {1'b0, 16'h00AB};
            8:  return {1'b0, 16'h0203};
            9:  return {1'b0, 16'h0004};
            10: return {1'b0, 16'h0009};
            11: return {1'b0, 16'h0020};
            12: return {1'b0, 16'h0002};
            13: return {1'b0, 16'h0002};
            14: return {1'b0, 16'h0004};
            15: return {1'b0, 16'h0000};
            default: begin
                if (addr < 80) return {1'b0, 16'(addr - 16)};
                return {1'b1, 16'h0000};
            end
        endcase
    endfunction

    task automatic do_req(input logic [7:0] a, input logic [7:0] l);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_len   = l;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    // consume n words; mode 1 uses the stall pattern 1,0,0,1,1,0,1
    task automatic stream(input logic [7:0] a, input int n, input int mode);
        int          idx;
        int          cyc;
        int          pat [7];
        logic        r;
        logic [16:0] e;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < n * 4 + 20) begin
            @(negedge clk);
            r = (mode == 1) ? (pat[cyc % 7] != 0) : 1'b1;
            bus.out_ready = r;
            e = model(int'(a) + idx);
            chk($sformatf("valid a=%0h i=%0d", a, idx), 32'(bus.out_valid), 32'd1);
            chk($sformatf("data a=%0h i=%0d", a, idx), 32'(bus.out_data), 32'(e[15:0]));
            chk($sformatf("err a=%0h i=%0d", a, idx), 32'(bus.out_err), 32'(e[16]));
            chk($sformatf("last a=%0h i=%0d", a, idx), 32'(bus.out_last), 32'(idx == n - 1));
            chk($sformatf("busy a=%0h i=%0d", a, idx), 32'(bus.req_ready), 32'd0);
            if (r) idx++;
            cyc++;
        end
        chk($sformatf("burst_count a=%0h", a), 32'(idx), 32'(n));
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk($sformatf("end_valid a=%0h", a), 32'(bus.out_valid), 32'd0);
        chk($sformatf("end_ready a=%0h", a), 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        vecs = '{
            '{8'h00, 16'h0004, 1'b0}, '{8'h01, 16'h0004, 1'b0},
            '{8'h02, 16'h0001, 1'b0}, '{8'h03, 16'h5678, 1'b0},
            '{8'h04, 16'h1234, 1'b0}, '{8'h05, 16'h0003, 1'b0},
            '{8'h06, 16'hCDEF, 1'b0}, '{8'h07, 16'h00AB, 1'b0},
            '{8'h08, 16'h0203, 1'b0}, '{8'h09, 16'h0004, 1'b0},
            '{8'h0A, 16'h0009, 1'b0}, '{8'h0B, 16'h0020, 1'b0},
            '{8'h0C, 16'h0002, 1'b0}, '{8'h0D, 16'h0002, 1'b0},
            '{8'h0E, 16'h0004, 1'b0}, '{8'h0F, 16'h0000, 1'b0},
            '{8'h10, 16'h0000, 1'b0}, '{8'h2A, 16'h001A, 1'b0},
            '{8'h4F, 16'h003F, 1'b0}, '{8'h50, 16'h0000, 1'b1},
            '{8'h80, 16'h0000, 1'b1}, '{8'hFF, 16'h0000, 1'b1}
        };
        bus.req_valid = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_len   = 8'h00;
        bus.out_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_out_data", 32'(bus.out_data), 32'd0);
        chk("idle_out_last", 32'(bus.out_last), 32'd0);
        chk("idle_out_err", 32'(bus.out_err), 32'd0);

        // single-word reads across the whole map and past its end
        for (int i = 0; i < 22; i++) begin
            do_req(vecs[i].addr, 8'd1);
            @(negedge clk);
            bus.out_ready = 1'b1;
            chk($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d data", i), 32'(bus.out_data), 32'(vecs[i].data));
            chk($sformatf("vec%0d err", i), 32'(bus.out_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d last", i), 32'(bus.out_last), 32'd1);
            @(negedge clk);
            bus.out_ready = 1'b0;
            chk($sformatf("vec%0d done", i), 32'(bus.out_valid), 32'd0);
        end

        // three-word burst from 0, no stalls
        do_req(8'h00, 8'd3);
        stream(8'h00, 3, 0);

        // CTLIST burst with stalls
        do_req(8'h10, 8'd4);
        stream(8'h10, 4, 1);

        // burst crossing the end of the map
        do_req(8'h4E, 8'd4);
        stream(8'h4E, 4, 0);

        // len 0 means 256 words, starting at 0xFF without wrapping
        do_req(8'hFF, 8'd0);
        stream(8'hFF, 256, 0);

        // request held while streaming is only taken after the burst
        do_req(8'h02, 8'd2);
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'h00;
        bus.req_len   = 8'd1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("hold_w0_data", 32'(bus.out_data), 32'h0001);
        chk("hold_w0_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("hold_w1_last", 32'(bus.out_last), 32'd1);
        @(negedge clk);
        chk("hold_gap_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_gap_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("hold_next_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_next_data", 32'(bus.out_data), 32'h0004);
        @(negedge clk);
        bus.out_ready = 1'b0;

        // reset during the second word of a five-word burst
        do_req(8'h10, 8'd5);
        @(negedge clk);
        bus.out_ready = 1'b1;
        chk("rb_w0", 32'(bus.out_data), 32'h0000);
        @(negedge clk);
        chk("rb_w1", 32'(bus.out_data), 32'h0001);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rb_valid", 32'(bus.out_valid), 32'd0);
        chk("rb_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        chk("rb_quiet", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        do_req(8'h01, 8'd1);
        stream(8'h01, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/optimsoc_config_streamer.md
Name: optimsoc_config_streamer

Overview:
- Read-only system-information server for the debug/host side of the tile array.
- Takes the static derived system configuration (config_t from optimsoc_config) as a parameter and flattens it into a fixed map of 16-bit words.
- Answers burst read requests (start address, length) with a valid/ready word stream.
- Feeds the debug subnet control logic, which forwards the words to the host for system enumeration.

Parameters:
- CONFIG, no usable default (must be supplied; config_t from derive_config), system configuration to publish.
- NUM_WORDS, 80, localparam (not overridable): size of the implemented word map, 0x00..0x4F.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  8  first word address
- req_len  in  8  word count; 0 means 256
- out_data  out  16  response word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid & out_ready
- out_last  out  1  marks final word of the burst
- out_err  out  1  current word address ≥ NUM_WORDS (data forced 0); valid only with out_valid

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Word map (all fields truncated or zero-extended to 16 bits):
  - 0x00 NUMTILES[15:0]
  - 0x01 NUMCTS[15:0]
  - 0x02 CORES_PER_TILE[15:0]
  - 0x03 GMEM_SIZE[15:0]
  - 0x04 GMEM_SIZE[31:16]
  - 0x05 GMEM_TILE[15:0]
  - 0x06 LMEM_SIZE[15:0]
  - 0x07 LMEM_SIZE[31:16]
  - 0x08 flags: bit0 NOC_ENABLE_VCHANNELS, bit1 ENABLE_BOOTROM, bit2 ENABLE_DM, bit3 ENABLE_PGAS, bit4 CORE_ENABLE_FPU, bit5 CORE_ENABLE_PERFCOUNTERS, bit6 NA_ENABLE_MPSIMPLE, bit7 NA_ENABLE_DMA, bit8 NA_DMA_GENIRQ, bit9 USE_DEBUG, bit10 DEBUG_STM, bit11 DEBUG_CTM, bit12 DEBUG_DEM_UART, bit13 DEBUG_SM, bit14 LMEM_STYLE==PLAIN, bit15 0
  - 0x09 TOTAL_NUM_CORES
  - 0x0A DEBUG_NUM_MODS
  - 0x0B NOC_FLIT_WIDTH
  - 0x0C NOC_CHANNELS
  - 0x0D DEBUG_MODS_PER_TILE
  - 0x0E NA_DMA_ENTRIES
  - 0x0F 0x0000
  - 0x10+i CTLIST[i] for i=0..63
  - The map is constant; it is built combinationally from CONFIG and muxed by the address counter.
- FSM states IDLE and STREAM.
  - IDLE: req_ready=1, out_valid=0. On handshake: addr_q←{1'b0,req_addr} (9 bit), rem_q←(req_len==0)?256:req_len (9 bit), go to STREAM.
  - STREAM: req_ready=0, out_valid=1. out_data, out_err and out_last are registered; the first word is valid on the cycle after request acceptance (latency 1).
  - STREAM, word handshake with rem_q>1: addr_q+=1, rem_q-=1, next word presented the following cycle. No bubbles: one word per cycle while out_ready=1.
  - STREAM, word handshake with rem_q==1: return to IDLE; req_ready=1 the cycle after, out_valid=0.
  - STREAM, out_ready=0: out_data, out_last and out_err hold stable.
- Address arithmetic:
  - addr_q is 9 bit and does not wrap; 0x0FF+1 = 0x100.
  - Any addr_q ≥ NUM_WORDS returns data 0x0000 with out_err=1.
  - The burst length is always honoured; errors never truncate the burst.
- out_last = (rem_q==1) in STREAM.
- Back-to-back: a new request cannot be accepted in the same cycle as the last word handshake; minimum one IDLE cycle between bursts.
- Reset values: req_ready=0 during the reset cycle, then 1 (IDLE); out_valid=0, out_last=0, out_err=0, out_data=0.
- Reset mid-burst: the burst is abandoned, out_valid=0 the next cycle, no further words; no partial state is retained.
- req_valid asserted while in STREAM is ignored (not accepted); the requester must hold it until req_ready.

Test Plan:
- CONFIG NUMTILES=4, NUMCTS=4, CTLIST={0,1,2,3,...}, CORES_PER_TILE=1; request addr=0x00 len=3, out_ready=1 → words 0x0004, 0x0004, 0x0001 on 3 consecutive cycles starting 1 cycle after accept; out_last on the 3rd; out_err=0; req_ready high the following cycle.
- Request addr=0x10 len=4 with out_ready toggling 1,0,0,1,1,0,1 → words 0,1,2,3 in order, each held stable while stalled, out_last only with word 3.
- Request addr=0x4E len=4 → 0x(CTLIST[62]), 0x(CTLIST[63]), 0x0000 err=1, 0x0000 err=1 with last.
- Request addr=0xFF len=0 → 256 words; first 0x0000 err=1; no wrap back to address 0x00 (all 256 have err=1); out_last on word 256.
- Flags with USE_DEBUG=1, ENABLE_BOOTROM=1, NOC_ENABLE_VCHANNELS=1, others 0; addr=0x08 len=1 → 0x0203.
- Assert rst for 1 cycle during word 2 of a 5-word burst → out_valid=0 the next cycle, req_ready=1 after, new request addr=0x01 len=1 → 0x0004.
